// File: rtl/cva6_ypb_data_arbiter.sv
// Four-to-one YPB data-side arbiter (load, store, PTW, ZCMT) with a source-ID FIFO for in-order response steering.
// Define CVA6_YPB_ARB_FIXED_PRIO_EN for fixed priority PTW > ZCMT > load > store instead of round-robin.
module cva6_ypb_data_arbiter #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [3:0]                    src_req_valid_i,
  output logic [3:0]                    src_req_ready_o,
  input  logic [3:0][PLEN-1:0]          src_addr_i,
  input  logic [3:0]                    src_we_i,
  input  logic [3:0][XLEN-1:0]          src_wdata_i,
  input  logic [3:0][XLEN/8-1:0]        src_be_i,
  output logic [3:0]                    src_rsp_valid_o,
  output logic [XLEN-1:0]               src_rdata_o,
  output logic                          src_err_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PLEN-1:0]               mem_addr_o,
  output logic                          mem_we_o,
  output logic [XLEN-1:0]               mem_wdata_o,
  output logic [XLEN/8-1:0]             mem_be_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [XLEN-1:0]               mem_rdata_i,
  input  logic                          mem_err_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [MaxOutstanding-1:0][1:0] fifo_q;
  logic [PtrW-1:0]                wptr_q, rptr_q;
  logic [CntW-1:0]                cnt_q;
  logic                           lock_q;
  logic [1:0]                     lock_idx_q;

  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [1:0] arb_gnt, gnt;
  logic [1:0] head;

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rptr_q];

`ifdef CVA6_YPB_ARB_FIXED_PRIO_EN
  // Fixed priority: PTW, ZCMT, load, store.
  always_comb begin
    arb_gnt = 2'd0;
    if (src_req_valid_i[2])      arb_gnt = 2'd2;
    else if (src_req_valid_i[3]) arb_gnt = 2'd3;
    else if (src_req_valid_i[0]) arb_gnt = 2'd0;
    else if (src_req_valid_i[1]) arb_gnt = 2'd1;
  end
`else
  logic [1:0] rr_ptr_q;

  // Round-robin: first valid source at or above rr_ptr, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    arb_gnt = rr_ptr_q;
    found   = 1'b0;
    cand    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = 2'(rr_ptr_q + 2'(i));
      if (!found && src_req_valid_i[cand]) begin
        arb_gnt = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= 2'd0;
    end else if (push) begin
      rr_ptr_q <= 2'(gnt + 2'd1);
    end
  end
`endif

  assign gnt = lock_q ? lock_idx_q : arb_gnt;

  // Request path: combinational mux of the granted source.
  assign mem_req_valid_o = (|src_req_valid_i) & ~fifo_full;
  assign mem_addr_o      = src_addr_i[gnt];
  assign mem_we_o        = src_we_i[gnt];
  assign mem_wdata_o     = src_wdata_i[gnt];
  assign mem_be_o        = src_be_i[gnt];
  assign push            = mem_req_valid_o & mem_req_ready_i;
  assign pop             = mem_rsp_valid_i & ~fifo_empty;

  always_comb begin
    src_req_ready_o      = 4'b0000;
    src_req_ready_o[gnt] = push;
  end

  // Response path: steer to the oldest outstanding source; drop if nothing is outstanding.
  always_comb begin
    src_rsp_valid_o = 4'b0000;
    if (pop) src_rsp_valid_o[head] = 1'b1;
  end

  assign src_rdata_o = mem_rdata_i;
  assign src_err_o   = mem_err_i;

  // Lock stays set from the first stalled cycle until the request handshakes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= 2'd0;
    end else if (lock_q) begin
      if (push) lock_q <= 1'b0;
    end else if (mem_req_valid_o && !mem_req_ready_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= gnt;
        wptr_q         <= PtrW'(wptr_q + PtrW'(1));
      end
      if (pop) rptr_q <= PtrW'(rptr_q + PtrW'(1));
      if (push && !pop)      cnt_q <= CntW'(cnt_q + CntW'(1));
      else if (!push && pop) cnt_q <= CntW'(cnt_q - CntW'(1));
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(lock_q && !src_req_valid_i[lock_idx_q]))
        else $error("locked source dropped request valid before handshake");
      assert (!(mem_rsp_valid_i && fifo_empty))
        else $warning("response with no outstanding request dropped");
    end
  end
`endif

endmodule

// File: tb/tb_cva6_ypb_data_arbiter.sv
// Directed, table-driven bench for cva6_ypb_data_arbiter.
module tb_cva6_ypb_data_arbiter;

  localparam int unsigned PLEN = 56;
  localparam int unsigned XLEN = 64;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [3:0]             src_req_valid_i;
  logic [3:0]             src_req_ready_o;
  logic [3:0][PLEN-1:0]   src_addr_i;
  logic [3:0]             src_we_i;
  logic [3:0][XLEN-1:0]   src_wdata_i;
  logic [3:0][XLEN/8-1:0] src_be_i;
  logic [3:0]             src_rsp_valid_o;
  logic [XLEN-1:0]        src_rdata_o;
  logic                   src_err_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [PLEN-1:0]        mem_addr_o;
  logic                   mem_we_o;
  logic [XLEN-1:0]        mem_wdata_o;
  logic [XLEN/8-1:0]      mem_be_o;
  logic                   mem_rsp_valid_i;
  logic [XLEN-1:0]        mem_rdata_i;
  logic                   mem_err_i;

  cva6_ypb_data_arbiter #(.PLEN(PLEN), .XLEN(XLEN), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .src_req_valid_i(src_req_valid_i), .src_req_ready_o(src_req_ready_o),
    .src_addr_i(src_addr_i), .src_we_i(src_we_i), .src_wdata_i(src_wdata_i), .src_be_i(src_be_i),
    .src_rsp_valid_o(src_rsp_valid_o), .src_rdata_o(src_rdata_o), .src_err_o(src_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       rdy;
    logic       rsp;
    logic [3:0] e_ready;
    logic       e_mv;
    logic [1:0] e_gnt;
    logic [3:0] e_rsp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic [3:0] v, input logic rd, input logic rs,
                     input logic [3:0] er, input logic emv, input logic [1:0] eg, input logic [3:0] ersp);
    vec_t x;
    x.rst_n = r; x.valid = v; x.rdy = rd; x.rsp = rs;
    x.e_ready = er; x.e_mv = emv; x.e_gnt = eg; x.e_rsp = ersp;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PLEN-1:0] addr_of(input logic [1:0] i);
    return PLEN'(64'h10_0000 + 64'(i) * 64'h100);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_addr_i[i]  = addr_of(2'(i));
      src_we_i[i]    = (i == 1);
      src_wdata_i[i] = XLEN'(64'hA5A5_0000_0000_0000 + 64'(i));
      src_be_i[i]    = (XLEN/8)'(8'h0F << i);
    end
    rst_ni = 1'b0; src_req_valid_i = 4'b0; mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;

    // rst, valid, rdy, rsp | ready, mem_valid, grant, rsp_valid
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000);
`ifndef CVA6_YPB_ARB_FIXED_PRIO_EN
    // round-robin with all sources valid, responses one cycle behind
    add(1, 4'b1111, 1, 0, 4'b0001, 1, 0, 4'b0000);
    add(1, 4'b1111, 1, 1, 4'b0010, 1, 1, 4'b0001);
    add(1, 4'b1111, 1, 1, 4'b0100, 1, 2, 4'b0010);
    add(1, 4'b1111, 1, 1, 4'b1000, 1, 3, 4'b0100);
    add(1, 4'b1111, 1, 1, 4'b0001, 1, 0, 4'b1000);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0001);
    // grant lock: load stalled, PTW arrives but load keeps the grant
    add(1, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 4'b0101, 0, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 4'b0101, 0, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 0, 4'b0000);
    add(1, 4'b0100, 1, 1, 4'b0100, 1, 2, 4'b0001);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0100);
    // FIFO full: four stores accepted, fifth stalls until a response
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0000, 0, 1, 4'b0000);
    add(1, 4'b0010, 1, 1, 4'b0000, 0, 1, 4'b0010);
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    // drain to two, then push a load while popping the older store
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0010);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0010);
    add(1, 4'b0001, 1, 1, 4'b0001, 1, 0, 4'b0010);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0010);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0001);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
    // reset with three outstanding, then a stale response is dropped
    add(1, 4'b1111, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b1111, 1, 0, 4'b0100, 1, 2, 4'b0000);
    add(1, 4'b1111, 1, 0, 4'b1000, 1, 3, 4'b0000);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
    add(1, 4'b0100, 1, 0, 4'b0100, 1, 2, 4'b0000);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0100);
`else
    // fixed priority: PTW, then load, then store
    add(1, 4'b0111, 1, 0, 4'b0100, 1, 2, 4'b0000);
    add(1, 4'b0011, 1, 0, 4'b0001, 1, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0100);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0001);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0010);
    // lock overrides the higher-priority PTW
    add(1, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 4'b0101, 0, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 4'b0101, 1, 0, 4'b0001, 1, 0, 4'b0000);
    add(1, 4'b0100, 1, 1, 4'b0100, 1, 2, 4'b0001);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0100);
`endif

    foreach (vecs[k]) begin
      @(negedge clk_i);
      rst_ni          = vecs[k].rst_n;
      src_req_valid_i = vecs[k].valid;
      mem_req_ready_i = vecs[k].rdy;
      mem_rsp_valid_i = vecs[k].rsp;
      #1;
      chk($sformatf("v%0d ready", k), 64'(src_req_ready_o), 64'(vecs[k].e_ready));
      chk($sformatf("v%0d mem_valid", k), 64'(mem_req_valid_o), 64'(vecs[k].e_mv));
      chk($sformatf("v%0d rsp_valid", k), 64'(src_rsp_valid_o), 64'(vecs[k].e_rsp));
      if (vecs[k].e_mv)
        chk($sformatf("v%0d addr", k), 64'(mem_addr_o), 64'(addr_of(vecs[k].e_gnt)));
    end

    // Store payload mux, then response data/error passthrough.
    @(negedge clk_i);
    src_req_valid_i = 4'b0010; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0;
    mem_rdata_i = 64'hDEAD_BEEF_0123_4567; mem_err_i = 1'b0;
    #1;
    chk("store ready", 64'(src_req_ready_o), 64'h2);
    chk("store we", 64'(mem_we_o), 64'h1);
    chk("store wdata", 64'(mem_wdata_o), 64'hA5A5_0000_0000_0001);
    chk("store be", 64'(mem_be_o), 64'h1E);
    chk("idle rdata passthrough", 64'(src_rdata_o), 64'hDEAD_BEEF_0123_4567);
    @(negedge clk_i);
    src_req_valid_i = 4'b0000; mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 64'h0F0F_1234_5678_9ABC; mem_err_i = 1'b1;
    #1;
    chk("store rsp valid", 64'(src_rsp_valid_o), 64'h2);
    chk("rsp rdata", 64'(src_rdata_o), 64'h0F0F_1234_5678_9ABC);
    chk("rsp err", 64'(src_err_o), 64'h1);
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0; mem_err_i = 1'b0;
    #1;
    chk("quiet rsp valid", 64'(src_rsp_valid_o), 64'h0);
    chk("quiet mem valid", 64'(mem_req_valid_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
